// File: rtl/bin2bcd_seq_pkg.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_pkg
// Shared constants and types for the sequential binary-to-BCD converter:
// operand widths, decimal saturation limits, FSM state encoding and the
// overflow test applied to a captured operand.
// ---------------------------------------------------------------------------
package bin2bcd_seq_pkg;

    localparam int DIGIT_W = 32'sd4;
    localparam int BIN_W   = 32'sd14;              // must stay >= 14 so 9999 fits
    localparam int DIGITS  = 32'sd4;
    localparam int BCD_W   = DIGIT_W * DIGITS;
    localparam int CNT_W   = $clog2(BIN_W);

    localparam logic [BIN_W-1:0] MAX_DEC = BIN_W'(32'd9999);
    // Every digit forced to 9; equals 16'h9999 for the 4-digit build.
    localparam logic [BCD_W-1:0] SAT_BCD = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // True when the operand cannot be shown on DIGITS decimal digits.
    function automatic logic is_over(input logic [BIN_W-1:0] value);
        return (value > MAX_DEC);
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_if
// Start/busy/done conversion handshake between a binary producer and the
// converter.
//   start    : producer -> converter, conversion request
//   binIn    : producer -> converter, unsigned operand
//   busy     : converter -> producer, conversion in progress
//   done     : converter -> producer, one-cycle result strobe
//   bcdOut   : converter -> producer, packed BCD (digit 3 in the top nibble)
//   overflow : converter -> producer, operand exceeded 9999
// ---------------------------------------------------------------------------
interface bin2bcd_seq_if;
    import bin2bcd_seq_pkg::*;

    logic             start;
    logic [BIN_W-1:0] binIn;
    logic             busy;
    logic             done;
    logic [BCD_W-1:0] bcdOut;
    logic             overflow;

    modport master (
        output start, binIn,
        input  busy, done, bcdOut, overflow
    );

    modport slave (
        input  start, binIn,
        output busy, done, bcdOut, overflow
    );

endinterface

// File: rtl/bin2bcd_seq_bcd_adj3.sv
// ---------------------------------------------------------------------------
// bcd_adj3
// Combinational single-digit correction of the shift-and-add-3 algorithm:
// a digit of 5 or more gets +3 so that the following left shift carries
// correctly into the next decimal digit.
//   digit : 4-bit BCD digit before correction
//   adj   : corrected digit
// ---------------------------------------------------------------------------
module bcd_adj3 (
    input  logic [3:0] digit,
    output logic [3:0] adj
);

    // Add 3 to digits in the range 5..9, pass the rest through.
    always_comb begin
        if (digit >= 4'd5) begin
            adj = digit + 4'd3;
        end else begin
            adj = digit;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter, one bit per clock (shift-and-add-3).
// Feeds the 16-bit data input of the 4-digit scanning display decoder.
// Operands above 9999 saturate to 9999 and raise overflow. Latency is a
// constant BIN_W+1 clocks from the accepting edge.
//   clk  : system clock, rising edge
//   rstN : asynchronous active-low reset
//   bus  : slave side of bin2bcd_seq_if (start, binIn, busy, done,
//          bcdOut, overflow)
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rstN,
    bin2bcd_seq_if.slave bus
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [BIN_W-1:0] shift_r;
    logic [BCD_W-1:0] scratch_r;
    logic [BCD_W-1:0] adj_s;
    logic [CNT_W-1:0] bit_cnt_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;
    logic             overflow_r;
    logic [BCD_W-1:0] bcd_out_r;
    logic             accept_s;
    logic             shift_en_s;
    logic             load_s;
    logic             last_shift_s;

    genvar g;
    generate
        for (g = 32'sd0; g < DIGITS; g = g + 32'sd1) begin : g_adj
            bcd_adj3 u_adj (
                .digit (scratch_r[g*DIGIT_W +: DIGIT_W]),
                .adj   (adj_s[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    assign last_shift_s = (bit_cnt_r == CNT_W'(BIN_W - 32'sd1));

    // Next-state decode and per-state datapath strobes.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        shift_en_s  = 1'b0;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    accept_s    = 1'b1;
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                shift_en_s = 1'b1;
                if (last_shift_s) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            LOAD: begin
                load_s      = 1'b1;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Conversion datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            shift_r    <= {BIN_W{1'b0}};
            scratch_r  <= {BCD_W{1'b0}};
            bit_cnt_r  <= {CNT_W{1'b0}};
            ovf_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
            bcd_out_r  <= {BCD_W{1'b0}};
        end else begin
            // busy follows the state the FSM is entering, so it is exact
            // without a combinational path from the state register.
            busy_r <= (state_nxt_s != IDLE);
            done_r <= load_s;
            if (accept_s) begin
                shift_r   <= bus.binIn;
                scratch_r <= {BCD_W{1'b0}};
                bit_cnt_r <= {CNT_W{1'b0}};
                ovf_r     <= is_over(bus.binIn);
            end else if (shift_en_s) begin
                // Scratch carry-out falls off the top; it is zero for any
                // representable operand and overflowed results are replaced.
                {scratch_r, shift_r} <= {adj_s, shift_r} << 1;
                bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            // Result changes only here, so the display never sees a partial value.
            if (load_s) begin
                bcd_out_r  <= ovf_r ? SAT_BCD : scratch_r;
                overflow_r <= ovf_r;
            end
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.bcdOut   = bcd_out_r;
    assign bus.overflow = overflow_r;

endmodule
